// File: rtl/fetch_decode_queue.sv
// Circular fetch-to-decode instruction buffer; a squash or reset empties it.
// Optional macro FETCH_DECODE_QUEUE_BYPASS_EN: zero-latency path from fetch to decode when the queue is empty.
module fetch_decode_queue #(
    parameter int p_depth        = 4,
    parameter int p_seq_num_bits = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      F_val,
    output logic                      F_rdy,
    input  logic [31:0]               F_inst,
    input  logic [31:0]               F_pc,
    input  logic [p_seq_num_bits-1:0] F_seq_num,
    output logic                      D_val,
    input  logic                      D_rdy,
    output logic [31:0]               D_inst,
    output logic [31:0]               D_pc,
    output logic [p_seq_num_bits-1:0] D_seq_num,
    input  logic                      squash_val,
    input  logic [p_seq_num_bits-1:0] squash_seq_num,
    input  logic [31:0]               squash_target
);
    localparam int PTR_W = $clog2(p_depth);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]               inst_q [p_depth];
    logic [31:0]               pc_q   [p_depth];
    logic [p_seq_num_bits-1:0] seq_q  [p_depth];
    logic [PTR_W-1:0]          head_q, head_d;
    logic [PTR_W-1:0]          tail_q, tail_d;
    logic [CNT_W-1:0]          count_q, count_d;

    logic empty, full, enq, deq, wr_en, rd_en;
    logic unused_squash_info;

    // Squash carries no age information this block needs; everything buffered is younger.
    assign unused_squash_info = ^{squash_seq_num, squash_target};

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(p_depth));

    // No full pass-through, so F_rdy never depends on D_rdy.
    assign F_rdy = !rst && !full;

`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
    always_comb begin
        if (empty) begin
            D_val     = !rst && !squash_val && F_val;
            D_inst    = F_inst;
            D_pc      = F_pc;
            D_seq_num = F_seq_num;
        end else begin
            D_val     = !rst && !squash_val;
            D_inst    = inst_q[head_q];
            D_pc      = pc_q[head_q];
            D_seq_num = seq_q[head_q];
        end
    end

    assign enq = F_val && F_rdy;
    assign deq = D_val && D_rdy;
    // A message handed straight to decode never touches storage.
    assign wr_en = enq && !squash_val && !(empty && deq);
    assign rd_en = deq && !empty;
`else
    assign D_val     = !rst && !squash_val && !empty;
    assign D_inst    = inst_q[head_q];
    assign D_pc      = pc_q[head_q];
    assign D_seq_num = seq_q[head_q];

    assign enq   = F_val && F_rdy;
    assign deq   = D_val && D_rdy;
    assign wr_en = enq && !squash_val;
    assign rd_en = deq;
`endif

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (wr_en) tail_d = tail_q + PTR_W'(1);
        if (rd_en) head_d = head_q + PTR_W'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || squash_val) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is never reset; it is only observed through D_val.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            inst_q[tail_q] <= F_inst;
            pc_q[tail_q]   <= F_pc;
            seq_q[tail_q]  <= F_seq_num;
        end
    end
endmodule
